// File: rtl/hippo_mem_arbiter.sv
// Round-robin arbiter sharing one registered-read memory port among NUM_REQ requesters.
// Read data is steered back to its requester through a tagged pipeline matched to RD_LAT.
module hippo_mem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i
);

    localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PipeD = RD_LAT + 1;

    typedef logic [IdW-1:0] id_t;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
    end

    id_t               ptr_q;
    id_t               ptr_d;
    id_t               grant_id;
    logic              grant_vld;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic [PipeD-1:0]  pipe_vld_q;
    id_t               pipe_id_q [PipeD];

    // First valid requester at or after ptr (wrapping) wins; nothing is granted in reset.
    always_comb begin : p_arb
        id_t cand;
        cand        = '0;
        grant_vld   = 1'b0;
        grant_id    = '0;
        req_ready_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = id_t'((32'(ptr_q) + i) % NUM_REQ);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        if (!rst_ni) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_id == id_t'(NUM_REQ - 1)) ? '0 : grant_id + id_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i < PipeD; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            we_q  <= grant_vld & req_we_i[grant_id];
            if (grant_vld) begin
                addr_q <= addr_arr[grant_id];
                data_q <= wdata_arr[grant_id];
            end
            // Stage k is visible k+1 cycles after accept; the last stage lines up with read data.
            pipe_vld_q   <= {pipe_vld_q[PipeD-2:0], grant_vld & ~req_we_i[grant_id]};
            pipe_id_q[0] <= grant_id;
            for (int unsigned i = 1; i < PipeD; i++) begin
                pipe_id_q[i] <= pipe_id_q[i-1];
            end
        end
    end

    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_we_o   = we_q;

    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        if (pipe_vld_q[RD_LAT]) begin
            rsp_valid_o[pipe_id_q[RD_LAT]] = 1'b1;
            rsp_rdata_o                    = mem_data_i;
        end
    end

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Directed bench for hippo_mem_arbiter with NUM_REQ=2, RD_LAT=1 and a registered-read memory.
module tb_hippo_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem [1024];

    int n_cmp = 0;
    int n_err = 0;
    int cnt0  = 0;
    int cnt1  = 0;

    hippo_mem_arbiter #(
        .NUM_REQ(2),
        .ADDR_W (10),
        .DATA_W (8),
        .RD_LAT (1)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .mem_addr_o (mem_addr),
        .mem_we_o   (mem_we),
        .mem_data_o (mem_wdata),
        .mem_data_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with one cycle registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic v, input logic we, input logic [9:0] a,
                           input logic [7:0] d);
        req_valid[k]           = v;
        req_we[k]              = we;
        req_addr[k*10 +: 10]   = a;
        req_wdata[k*8 +: 8]    = d;
    endtask

    task automatic clear_req();
        req_valid = 2'b00;
        req_we    = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]    = 8'h11;
        mem[1]    = 8'h22;
        mem[5]    = 8'h3C;
        mem[1023] = 8'hE1;
        mem_rdata = 8'h00;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b0;
        set_req(0, 1'b1, 1'b0, 10'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 10'd0, 8'h00);

        // Reset held with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            check_eq($sformatf("rst_ready_%0d", i), 32'(req_ready), 32'h0);
            check_eq($sformatf("rst_we_%0d", i), 32'(mem_we), 32'h0);
            check_eq($sformatf("rst_rsp_%0d", i), 32'(rsp_valid), 32'h0);
        end
        check_eq("rst_addr", 32'(mem_addr), 32'h0);

        // Release: requester 0 first.
        next_cycle();
        rst_n = 1'b1;
        settle();
        check_eq("rel_ready", 32'(req_ready), 32'h1);
        next_cycle();
        clear_req();
        settle();
        check_eq("rel_addr", 32'(mem_addr), 32'h0);
        check_eq("rel_rsp_early", 32'(rsp_valid), 32'h0);
        next_cycle();
        settle();
        check_eq("rel_rsp", 32'(rsp_valid), 32'h1);
        check_eq("rel_rdata", 32'(rsp_rdata), 32'h11);
        next_cycle();
        settle();
        check_eq("rel_rsp_end", 32'(rsp_valid), 32'h0);

        // Single read by requester 1 of addr 5.
        next_cycle();
        set_req(1, 1'b1, 1'b0, 10'd5, 8'h00);
        settle();
        check_eq("rd_ready", 32'(req_ready), 32'h2);
        next_cycle();
        clear_req();
        settle();
        check_eq("rd_addr", 32'(mem_addr), 32'd5);
        check_eq("rd_rsp_early", 32'(rsp_valid), 32'h0);
        next_cycle();
        settle();
        check_eq("rd_rsp", 32'(rsp_valid), 32'h2);
        check_eq("rd_rdata", 32'(rsp_rdata), 32'h3C);
        next_cycle();
        settle();
        check_eq("rd_rsp_end", 32'(rsp_valid), 32'h0);

        // Requester 0 writes A7 to addr 10, then reads it back.
        next_cycle();
        set_req(0, 1'b1, 1'b1, 10'd10, 8'hA7);
        settle();
        check_eq("wr_ready", 32'(req_ready), 32'h1);
        check_eq("wr_we_pre", 32'(mem_we), 32'h0);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'd10, 8'h00);
        settle();
        check_eq("wr_rd_ready", 32'(req_ready), 32'h1);
        check_eq("wr_we", 32'(mem_we), 32'h1);
        check_eq("wr_addr", 32'(mem_addr), 32'd10);
        check_eq("wr_data", 32'(mem_wdata), 32'hA7);
        next_cycle();
        clear_req();
        settle();
        check_eq("wr_we_post", 32'(mem_we), 32'h0);
        check_eq("wr_rsp_none", 32'(rsp_valid), 32'h0);
        next_cycle();
        settle();
        check_eq("wr_rd_rsp", 32'(rsp_valid), 32'h1);
        check_eq("wr_rd_rdata", 32'(rsp_rdata), 32'hA7);
        next_cycle();
        settle();
        check_eq("wr_rd_rsp_end", 32'(rsp_valid), 32'h0);

        // Requester 1 write: no response expected.
        next_cycle();
        set_req(1, 1'b1, 1'b1, 10'd200, 8'h55);
        settle();
        check_eq("w1_ready", 32'(req_ready), 32'h2);
        next_cycle();
        clear_req();
        settle();
        check_eq("w1_we", 32'(mem_we), 32'h1);
        check_eq("w1_addr", 32'(mem_addr), 32'd200);
        check_eq("w1_data", 32'(mem_wdata), 32'h55);
        next_cycle();
        settle();
        check_eq("w1_we_post", 32'(mem_we), 32'h0);
        check_eq("w1_rsp0", 32'(rsp_valid), 32'h0);
        next_cycle();
        settle();
        check_eq("w1_rsp1", 32'(rsp_valid), 32'h0);

        // Fairness: both valid for 8 cycles, responses two cycles behind grants.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c < 8) begin
                set_req(0, 1'b1, 1'b0, 10'd0, 8'h00);
                set_req(1, 1'b1, 1'b0, 10'd1, 8'h00);
            end else begin
                clear_req();
            end
            settle();
            if (c < 8) begin
                check_eq($sformatf("fair_ready_%0d", c), 32'(req_ready),
                         (c % 2 == 0) ? 32'h1 : 32'h2);
            end
            if (c >= 2) begin
                check_eq($sformatf("fair_rsp_%0d", c), 32'(rsp_valid),
                         (c % 2 == 0) ? 32'h1 : 32'h2);
                check_eq($sformatf("fair_rdata_%0d", c), 32'(rsp_rdata),
                         (c % 2 == 0) ? 32'h11 : 32'h22);
            end else begin
                check_eq($sformatf("fair_rsp_%0d", c), 32'(rsp_valid), 32'h0);
            end
            if (rsp_valid[0]) cnt0++;
            if (rsp_valid[1]) cnt1++;
        end
        next_cycle();
        settle();
        check_eq("fair_rsp_end", 32'(rsp_valid), 32'h0);
        check_eq("fair_cnt0", 32'(cnt0), 32'd4);
        check_eq("fair_cnt1", 32'(cnt1), 32'd4);

        // Wrap and idle: requester 1 reads 1023 then 0.
        next_cycle();
        set_req(1, 1'b1, 1'b0, 10'd1023, 8'h00);
        settle();
        check_eq("wrap_ready0", 32'(req_ready), 32'h2);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 10'd0, 8'h00);
        settle();
        check_eq("wrap_ready1", 32'(req_ready), 32'h2);
        check_eq("wrap_addr_hi", 32'(mem_addr), 32'd1023);
        next_cycle();
        clear_req();
        settle();
        check_eq("wrap_addr_lo", 32'(mem_addr), 32'd0);
        check_eq("wrap_rsp0", 32'(rsp_valid), 32'h2);
        check_eq("wrap_rdata0", 32'(rsp_rdata), 32'hE1);
        next_cycle();
        settle();
        check_eq("wrap_rsp1", 32'(rsp_valid), 32'h2);
        check_eq("wrap_rdata1", 32'(rsp_rdata), 32'h11);
        check_eq("wrap_addr_hold0", 32'(mem_addr), 32'd0);
        next_cycle();
        settle();
        check_eq("wrap_rsp_end", 32'(rsp_valid), 32'h0);
        check_eq("wrap_addr_hold1", 32'(mem_addr), 32'd0);
        check_eq("wrap_we_idle", 32'(mem_we), 32'h0);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 10'd1, 8'h00);
        settle();
        check_eq("wrap_ptr0", 32'(req_ready), 32'h1);
        next_cycle();
        clear_req();
        settle();
        next_cycle();
        settle();
        check_eq("wrap_p_rsp", 32'(rsp_valid), 32'h1);
        check_eq("wrap_p_rdata", 32'(rsp_rdata), 32'h11);

        // Mid-flight reset drops the in-flight read.
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'd5, 8'h00);
        settle();
        check_eq("mr_ready", 32'(req_ready), 32'h1);
        next_cycle();
        clear_req();
        rst_n = 1'b0;
        settle();
        check_eq("mr_rsp_rst", 32'(rsp_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            rst_n = 1'b1;
            settle();
            check_eq($sformatf("mr_rsp_%0d", i), 32'(rsp_valid), 32'h0);
        end
        next_cycle();
        set_req(1, 1'b1, 1'b0, 10'd5, 8'h00);
        settle();
        check_eq("mr_post_ready", 32'(req_ready), 32'h2);
        next_cycle();
        clear_req();
        settle();
        check_eq("mr_post_addr", 32'(mem_addr), 32'd5);
        next_cycle();
        settle();
        check_eq("mr_post_rsp", 32'(rsp_valid), 32'h2);
        check_eq("mr_post_rdata", 32'(rsp_rdata), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
